// File: rtl/axi4_refill_resp_deser_mid.sv
// rtl/axi4_refill_resp_deser_mid.sv - multi-ID AXI4 R-beat to cache-line deserializer
//
// Purpose:
//   Assembles AXI R beats into full cache lines in N_SLOTS independent
//   slots selected by the low RID bits. RRESP is merged per line, burst
//   length errors are flagged, and completed lines leave through one
//   registered valid/ready output stage fed by a round-robin arbiter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bypass_i            every accepted beat completes a line (lane 0)
//   init_r*_i/o         AXI4 R channel (id, data, resp, last, user, valid, ready)
//   line_*_o            completed line: id, data, merged resp, first-beat user, err
//   line_valid_o/ready_i  output handshake
module axi4_refill_resp_deser_mid #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_WIDTH = 32,
  parameter int AXI_DATA   = 64,
  parameter int AXI_ID     = 6,
  parameter int AXI_USER   = 8,
  parameter int N_SLOTS    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bypass_i,
  input  logic [AXI_ID-1:0]                init_rid_i,
  input  logic [AXI_DATA-1:0]              init_rdata_i,
  input  logic [1:0]                       init_rresp_i,
  input  logic                             init_rlast_i,
  input  logic [AXI_USER-1:0]              init_ruser_i,
  input  logic                             init_rvalid_i,
  output logic                             init_rready_o,
  output logic [AXI_ID-1:0]                line_id_o,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] line_data_o,
  output logic [1:0]                       line_resp_o,
  output logic [AXI_USER-1:0]              line_user_o,
  output logic                             line_err_o,
  output logic                             line_valid_o,
  input  logic                             line_ready_i
);

  localparam int LINE_W = LINE_WORDS * WORD_WIDTH;
  localparam int BEATS  = LINE_W / AXI_DATA;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [SLOT_W-1:0] SLOT_MASK = SLOT_W'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_DONE    = 2'd2
  } slot_state_e;

  slot_state_e         r_state     [N_SLOTS];
  slot_state_e         w_state_nxt [N_SLOTS];
  logic [CNT_W-1:0]    r_cnt       [N_SLOTS];
  logic [AXI_DATA-1:0] r_data      [N_SLOTS][BEATS];
  logic [AXI_ID-1:0]   r_id        [N_SLOTS];
  logic [AXI_USER-1:0] r_user      [N_SLOTS];
  logic [1:0]          r_resp      [N_SLOTS];
  logic                r_err       [N_SLOTS];
  // Set once the final lane is written without rlast; further beats are dropped.
  logic                r_ovf       [N_SLOTS];

  logic                r_out_valid;
  logic [AXI_ID-1:0]   r_line_id;
  logic [LINE_W-1:0]   r_line_data;
  logic [1:0]          r_line_resp;
  logic [AXI_USER-1:0] r_line_user;
  logic                r_line_err;
  logic [SLOT_W-1:0]   r_last_grant;

  logic [SLOT_W-1:0]   w_slot;
  logic                w_accept;
  logic [N_SLOTS-1:0]  w_done;
  logic [SLOT_W-1:0]   w_grant;
  logic                w_grant_vld;
  logic [SLOT_W-1:0]   w_rr_idx;
  logic                w_load;

  // EXOKAY is folded into OKAY so the stored codes 00/10/11 order by severity.
  function automatic logic [1:0] f_norm(input logic [1:0] resp);
    return (resp == 2'b01) ? 2'b00 : resp;
  endfunction

  function automatic logic [1:0] f_merge(input logic [1:0] acc, input logic [1:0] resp);
    logic [1:0] n;
    n = f_norm(resp);
    return (n > acc) ? n : acc;
  endfunction

  assign w_slot   = init_rid_i[SLOT_W-1:0] & SLOT_MASK;
  assign w_accept = init_rvalid_i & init_rready_o;
  assign w_load   = w_grant_vld & (~r_out_valid | line_ready_i);

  // Slot FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SLOTS; s++) r_state[s] <= S_EMPTY;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) r_state[s] <= w_state_nxt[s];
    end
  end

  // Slot FSM: next state. A slot being loaded is DONE, so it can never
  // also be the target of an accepted beat in the same cycle.
  always_comb begin
    for (int s = 0; s < N_SLOTS; s++) begin
      w_state_nxt[s] = r_state[s];
      if (w_load && (w_grant == SLOT_W'(s))) begin
        w_state_nxt[s] = S_EMPTY;
      end else if (w_accept && (w_slot == SLOT_W'(s))) begin
        if (bypass_i || init_rlast_i) w_state_nxt[s] = S_DONE;
        else                          w_state_nxt[s] = S_FILLING;
      end
    end
  end

  // Slot FSM: outputs
  always_comb begin
    w_done = '0;
    for (int s = 0; s < N_SLOTS; s++) w_done[s] = (r_state[s] == S_DONE);
    init_rready_o = ~rst & (r_state[w_slot] != S_DONE);
  end

  // Round-robin search starting one past the last granted slot.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_rr_idx    = '0;
    for (int i = 1; i <= N_SLOTS; i++) begin
      w_rr_idx = (r_last_grant + SLOT_W'(i)) & SLOT_MASK;
      if (!w_grant_vld && w_done[w_rr_idx]) begin
        w_grant     = w_rr_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  // Slot datapath: only the addressed slot changes on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        r_cnt[s]  <= '0;
        r_id[s]   <= '0;
        r_user[s] <= '0;
        r_resp[s] <= '0;
        r_err[s]  <= 1'b0;
        r_ovf[s]  <= 1'b0;
        for (int k = 0; k < BEATS; k++) r_data[s][k] <= '0;
      end
    end else if (w_accept) begin
      if (r_state[w_slot] == S_EMPTY) begin
        r_id[w_slot]   <= init_rid_i;
        r_user[w_slot] <= init_ruser_i;
        r_resp[w_slot] <= f_norm(init_rresp_i);
        r_err[w_slot]  <= 1'b0;
      end else begin
        r_resp[w_slot] <= f_merge(r_resp[w_slot], init_rresp_i);
      end

      if (bypass_i) begin
        r_data[w_slot][0] <= init_rdata_i;
        r_cnt[w_slot]     <= '0;
        r_ovf[w_slot]     <= 1'b0;
        // bypass raised under a partially filled line
        if (r_state[w_slot] == S_FILLING) r_err[w_slot] <= 1'b1;
      end else if (r_ovf[w_slot]) begin
        r_err[w_slot] <= 1'b1;
        if (init_rlast_i) begin
          r_cnt[w_slot] <= '0;
          r_ovf[w_slot] <= 1'b0;
        end
      end else begin
        r_data[w_slot][r_cnt[w_slot]] <= init_rdata_i;
        if (init_rlast_i) begin
          r_cnt[w_slot] <= '0;
          if (r_cnt[w_slot] != LAST_CNT) r_err[w_slot] <= 1'b1;
        end else if (r_cnt[w_slot] == LAST_CNT) begin
          r_ovf[w_slot] <= 1'b1;
        end else begin
          r_cnt[w_slot] <= r_cnt[w_slot] + 1'b1;
        end
      end
    end
  end

  // Output register: loads when empty or when being popped this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_line_id    <= '0;
      r_line_data  <= '0;
      r_line_resp  <= '0;
      r_line_user  <= '0;
      r_line_err   <= 1'b0;
      r_last_grant <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_line_id   <= r_id[w_grant];
      for (int k = 0; k < BEATS; k++) r_line_data[k*AXI_DATA +: AXI_DATA] <= r_data[w_grant][k];
      // a length error reports at least SLVERR
      r_line_resp  <= (r_err[w_grant] && (r_resp[w_grant] < 2'b10)) ? 2'b10 : r_resp[w_grant];
      r_line_user  <= r_user[w_grant];
      r_line_err   <= r_err[w_grant];
      r_last_grant <= w_grant;
    end else if (line_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign line_valid_o = r_out_valid;
  assign line_id_o    = r_line_id;
  assign line_data_o  = r_line_data;
  assign line_resp_o  = r_line_resp;
  assign line_user_o  = r_line_user;
  assign line_err_o   = r_line_err;

endmodule

// File: doc/axi4_refill_resp_deser_mid.md
Name: axi4_refill_resp_deser_mid

Overview:
- Multi-ID AXI4 read-response deserializer for the icache refill path.
- Collects AXI_DATA-wide R beats into full cache lines, LINE_WORDS x WORD_WIDTH bits.
- Keeps N_SLOTS independent assembly slots indexed by the low RID bits, so interleaved bursts of different IDs are assembled in parallel.
- Merges per-beat RRESP, flags burst-length errors, supports single-beat bypass, and presents completed lines to the cache controller via valid/ready through one registered output stage.

Parameters:
- LINE_WORDS, 4, words per cache line.
- WORD_WIDTH, 32, bits per word.
- AXI_DATA, 64, R data width. LINE_WORDS*WORD_WIDTH/AXI_DATA = BEATS, a power of two >= 1.
- AXI_ID, 6, RID width.
- AXI_USER, 8, RUSER width.
- N_SLOTS, 4, assembly slots. Power of two, <= 2^AXI_ID. Slot index = rid[log2(N_SLOTS)-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- bypass_i  in  1  bypass mode: every beat completes a line.
- init_rid_i  in  AXI_ID  R channel ID.
- init_rdata_i  in  AXI_DATA  R channel data.
- init_rresp_i  in  2  R channel response.
- init_rlast_i  in  1  R channel last beat.
- init_ruser_i  in  AXI_USER  R channel user.
- init_rvalid_i  in  1  R channel valid.
- init_rready_o  out  1  R channel ready.
- line_id_o  out  AXI_ID  RID of the completed line.
- line_data_o  out  LINE_WORDS*WORD_WIDTH  line data; beat k in bits [k*AXI_DATA +: AXI_DATA].
- line_resp_o  out  2  merged response.
- line_user_o  out  AXI_USER  RUSER of the first beat.
- line_err_o  out  1  burst-length error.
- line_valid_o  out  1  line valid.
- line_ready_i  in  1  line ready.

Behaviour:
- Reset (rst=1, async):
  - All slots empty; all counters 0.
  - Output register empty; line_valid_o=0; all line_* outputs 0; init_rready_o=0.
  - Reset mid-burst discards partial lines. The AXI master is reset alongside.
- Slot state: EMPTY -> FILLING -> DONE -> EMPTY.
  - Each slot holds: beat counter cnt (width log2(BEATS), min 1), data buffer, id, first-beat user, resp_acc, err flag.
- init_rready_o = ~rst & (state of addressed slot != DONE). It depends combinationally on init_rid_i; there is no dependence on line_ready_i.
- A beat is accepted when rvalid & rready.
  - In EMPTY: store user and id, resp_acc=rresp, err=0.
  - Data is written to lane cnt. Unwritten lanes keep stale data.
- On accepted beat, non-bypass:
  - If rlast & cnt==BEATS-1: go to DONE, cnt=0.
  - If rlast & cnt<BEATS-1 (short burst): go to DONE, err=1.
  - If !rlast & cnt==BEATS-1: state is FILLING, cnt held. Later beats up to rlast are accepted, not written, set err=1; rlast then gives DONE (overlong burst).
  - Otherwise cnt+1, state FILLING.
- Bypass (bypass_i sampled per beat):
  - Accepted beat goes to lane 0 and the slot goes DONE immediately, err=0.
  - rlast is ignored.
  - bypass_i must not toggle while any slot is FILLING. If it does, err=1 for that slot.
- RRESP merge, severity order DECERR > SLVERR > OKAY. EXOKAY counts as OKAY.
  - resp_acc = most severe value seen.
  - err=1 forces line_resp_o to at least SLVERR.
- Output stage:
  - Register loads when it is empty, or when line_valid_o & line_ready_i in the same cycle (full-throughput pop+load).
  - A round-robin arbiter picks among DONE slots, starting after the last granted slot.
  - Selected slot becomes EMPTY in the load cycle and may accept a new beat from the next cycle.
  - Latency: last beat accepted at cycle t -> line_valid_o=1 at t+2 minimum (slot DONE at t+1, register loaded at t+2).
  - line_valid_o holds stable with data until line_ready_i.
- Backpressure: with the output stalled, a slot in DONE blocks only its own ID. Other IDs continue to fill. When all slots are DONE, rready=0 for all IDs.
- Simultaneous events:
  - A beat to slot s cannot coincide with s leaving DONE; rready is low for s that cycle.
  - Pop and load in the same cycle is allowed.
- IDs aliasing to the same slot with interleaved beats are illegal. No detection is required.

Test Plan:
- BEATS=2, ID 5: beats 0xA, 0xB (rlast), OKAY -> line_data_o={0xB,0xA}, id 5, resp 00, err 0, valid 2 cycles after last beat.
- Interleave ID1 b0, ID2 b0, ID1 b1 (last), ID2 b1 (last) -> two lines, ID1 then ID2, no data mixing.
- Beat resps OKAY, DECERR -> line_resp_o=11. Resps EXOKAY, OKAY -> 00.
- Short burst (rlast on beat 0, BEATS=2) -> err=1, resp=10. Overlong burst (3 beats) -> err=1, lanes hold first 2 beats.
- line_ready_i=0 with ID0 line pending; send ID0 and ID1 bursts -> ID0 beats stalled (rready=0), ID1 completes. Release ready -> ID0 line, then ID1 line, then stalled ID0 burst accepted.
- Bypass=1, three single beats IDs 0,1,2 with line_ready_i=1 -> three lines, data in lane 0. Assert rst mid-burst -> line_valid_o=0, rready=0 while rst is high.
